// File: rtl/ks_add_arbiter.sv
`timescale 1ns/1ps
// Round-robin arbiter sharing one 16-bit Kogge-Stone adder between requesters.
// Each requester keeps its own carry flag so chained adds can interleave.

module ks_add16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout
);
    logic [15:0] p0;
    logic [15:0] g;
    logic [15:0] p;
    logic [15:0] gn;
    logic [15:0] pn;

    // Parallel-prefix carry tree; cin is folded into bit 0's generate.
    always_comb begin
        p0 = a ^ b;
        g = a & b;
        p = p0;
        g[0] = g[0] | (p0[0] & cin);
        for (int s = 0; s < 4; s++) begin
            gn = g;
            pn = p;
            for (int i = 0; i < 16; i++) begin
                if (i >= (1 << s)) begin
                    gn[i] = g[i] | (p[i] & g[i-(1<<s)]);
                    pn[i] = p[i] & p[i-(1<<s)];
                end
            end
            g = gn;
            p = pn;
        end
        sum = p0 ^ {g[14:0], cin};
        cout = g[15];
    end
endmodule

module ks_add_arbiter #(
    parameter int N_REQ = 4,
    parameter int W = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_REQ-1:0]              req_valid,
    output logic [N_REQ-1:0]              req_ready,
    input  logic [N_REQ*16-1:0]           req_a,
    input  logic [N_REQ*16-1:0]           req_b,
    input  logic [N_REQ-1:0]              req_cin,
    input  logic [N_REQ-1:0]              req_chain,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [$clog2(N_REQ)-1:0]      rsp_id,
    output logic [15:0]                   rsp_sum,
    output logic                          rsp_cout
);
    localparam int IDW = $clog2(N_REQ);

    if (W != 16) begin : g_bad_width
        $error("ks_add_arbiter: W must be 16");
    end

    logic             rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]   rsp_id_q, rsp_id_d;
    logic [15:0]      rsp_sum_q, rsp_sum_d;
    logic             rsp_cout_q, rsp_cout_d;
    logic [N_REQ-1:0] carry_q, carry_d;
    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;

    logic             slot_free;
    logic             gnt;
    logic [IDW-1:0]   gnt_id;
    logic [15:0]      add_a, add_b;
    logic             add_cin;
    logic [15:0]      add_sum;
    logic             add_cout;

    // Rotating priority search starting at rr_ptr, only when the slot frees.
    always_comb begin
        slot_free = !rsp_valid_q | rsp_ready;
        gnt = 1'b0;
        gnt_id = '0;
        if (slot_free) begin
            for (int k = 0; k < N_REQ; k++) begin
                if (!gnt && req_valid[(int'(rr_ptr_q) + k) % N_REQ]) begin
                    gnt = 1'b1;
                    gnt_id = IDW'((int'(rr_ptr_q) + k) % N_REQ);
                end
            end
        end
        req_ready = gnt ? (N_REQ'(1) << gnt_id) : '0;
    end

    // Operand mux for the granted requester, with chained carry selection.
    always_comb begin
        add_a = req_a[int'(gnt_id)*16 +: 16];
        add_b = req_b[int'(gnt_id)*16 +: 16];
        add_cin = req_chain[gnt_id] ? carry_q[gnt_id] : req_cin[gnt_id];
    end

    ks_add16 u_add (
        .a    (add_a),
        .b    (add_b),
        .cin  (add_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Next state for response register, carry flags and pointer.
    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_id_d = rsp_id_q;
        rsp_sum_d = rsp_sum_q;
        rsp_cout_d = rsp_cout_q;
        carry_d = carry_q;
        rr_ptr_d = rr_ptr_q;
        if (gnt) begin
            rsp_valid_d = 1'b1;
            rsp_id_d = gnt_id;
            rsp_sum_d = add_sum;
            rsp_cout_d = add_cout;
            carry_d[gnt_id] = add_cout;
            rr_ptr_d = (gnt_id == IDW'(N_REQ - 1)) ? '0 : gnt_id + 1'b1;
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_id_q <= '0;
            rsp_sum_q <= '0;
            rsp_cout_q <= 1'b0;
            carry_q <= '0;
            rr_ptr_q <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q <= rsp_id_d;
            rsp_sum_q <= rsp_sum_d;
            rsp_cout_q <= rsp_cout_d;
            carry_q <= carry_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id = rsp_id_q;
    assign rsp_sum = rsp_sum_q;
    assign rsp_cout = rsp_cout_q;
endmodule

// File: tb/tb_ks_add_arbiter.sv
`timescale 1ns/1ps
// Testbench for ks_add_arbiter: scenario tasks checked against a
// behavioural model of the arbiter and integer addition.

module tb_ks_add_arbiter;
    localparam int N = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req_valid;
    logic [N-1:0]  req_ready;
    logic [N*16-1:0] req_a;
    logic [N*16-1:0] req_b;
    logic [N-1:0]  req_cin;
    logic [N-1:0]  req_chain;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [1:0]    rsp_id;
    logic [15:0]   rsp_sum;
    logic          rsp_cout;

    int checks = 0;
    int errors = 0;

    // Model state
    int          m_ptr;
    bit          m_carry [N];
    bit          m_rv;
    int          m_id;
    logic [15:0] m_sum;
    bit          m_cout;

    ks_add_arbiter #(.N_REQ(N), .W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
        .req_chain (req_chain),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout)
    );

    always #5 clk = ~clk;

    function automatic int m_grant();
        if (m_rv && !rsp_ready) return -1;
        for (int k = 0; k < N; k++)
            if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
        return -1;
    endfunction

    function automatic logic [N-1:0] m_ready();
        int g;
        g = m_grant();
        return (g < 0) ? '0 : (N'(1) << g);
    endfunction

    // Advance one clock; the model applies the rules to the pre-edge inputs.
    task automatic tick(output int g);
        logic [16:0] r;
        bit c;
        g = m_grant();
        if (g >= 0) begin
            c = req_chain[g] ? m_carry[g] : req_cin[g];
            r = {1'b0, req_a[g*16 +: 16]} + {1'b0, req_b[g*16 +: 16]} + 17'(c);
        end
        @(posedge clk);
        if (rst) begin
            m_ptr = 0; m_rv = 0; m_id = 0; m_sum = 0; m_cout = 0;
            for (int i = 0; i < N; i++) m_carry[i] = 0;
            g = -1;
        end else if (g >= 0) begin
            m_rv = 1; m_id = g; m_sum = r[15:0]; m_cout = r[16];
            m_carry[g] = r[16];
            m_ptr = (g + 1) % N;
        end else if (rsp_ready) begin
            m_rv = 0;
        end
        #1;
    endtask

    task automatic set_req(int i, logic [15:0] a, logic [15:0] b, bit cin, bit chain);
        req_valid[i] = 1'b1;
        req_a[i*16 +: 16] = a;
        req_b[i*16 +: 16] = b;
        req_cin[i] = cin;
        req_chain[i] = chain;
    endtask

    task automatic clear_reqs();
        req_valid = '0;
        req_cin = '0;
        req_chain = '0;
    endtask

    task automatic test_reset();
        int g;
        rst = 1; rsp_ready = 1; clear_reqs(); req_a = '0; req_b = '0;
        tick(g); tick(g);
        rst = 0;
        #1;
        checks++;
        if (rsp_valid !== 1'b0) begin errors++;
            $display("FAIL reset_valid: got %b want 0", rsp_valid); end
        checks++;
        if (rsp_id !== 2'd0 || rsp_sum !== 16'h0 || rsp_cout !== 1'b0) begin errors++;
            $display("FAIL reset_fields: got id=%0d sum=%h cout=%b want 0/0000/0",
                     rsp_id, rsp_sum, rsp_cout); end
        checks++;
        if (req_ready !== 4'b0000) begin errors++;
            $display("FAIL reset_ready: got %b want 0000", req_ready); end
    endtask

    task automatic test_basic();
        int g;
        for (int c = 0; c < 2; c++) begin
            clear_reqs();
            set_req(0, 16'h1234, 16'h4321, c[0], 1'b0);
            #1;
            checks++;
            if (req_ready !== 4'b0001) begin errors++;
                $display("FAIL basic_ready: got %b want 0001", req_ready); end
            tick(g);
            clear_reqs();
            #1;
            checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 ||
                rsp_sum !== (c ? 16'h5556 : 16'h5555) || rsp_cout !== 1'b0) begin
                errors++;
                $display("FAIL basic_rsp: got v=%b id=%0d sum=%h cout=%b want 1/0/%h/0",
                         rsp_valid, rsp_id, rsp_sum, rsp_cout, c ? 16'h5556 : 16'h5555);
            end
            tick(g);
        end
    endtask

    task automatic test_chain();
        int g;
        logic [15:0] a_v [3] = '{16'hFFFF, 16'h0000, 16'h0000};
        logic [15:0] b_v [3] = '{16'h0001, 16'h0000, 16'h0000};
        bit ch_v [3] = '{1'b0, 1'b1, 1'b1};
        logic [15:0] es [3] = '{16'h0000, 16'h0001, 16'h0000};
        bit ec [3] = '{1'b1, 1'b0, 1'b0};
        for (int k = 0; k < 3; k++) begin
            clear_reqs();
            set_req(1, a_v[k], b_v[k], 1'b0, ch_v[k]);
            tick(g);
            clear_reqs();
            #1;
            checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 ||
                rsp_sum !== es[k] || rsp_cout !== ec[k]) begin
                errors++;
                $display("FAIL chain_%0d: got v=%b id=%0d sum=%h cout=%b want 1/1/%h/%b",
                         k, rsp_valid, rsp_id, rsp_sum, rsp_cout, es[k], ec[k]);
            end
        end
        tick(g);
    endtask

    task automatic test_round_robin();
        int g;
        int prev = -1;
        rsp_ready = 1;
        clear_reqs();
        for (int i = 0; i < N; i++)
            set_req(i, 16'($urandom), 16'($urandom), 1'($urandom), 1'b0);
        for (int cyc = 0; cyc < 12; cyc++) begin
            #1;
            checks++;
            if (req_ready !== m_ready() ||
                (prev >= 0 && req_ready !== (N'(1) << ((prev + 1) % N)))) begin
                errors++;
                $display("FAIL rr_grant_%0d: got %b want %b", cyc, req_ready, m_ready());
            end
            tick(g);
            prev = g;
            checks++;
            if (rsp_valid !== 1'b1 || int'(rsp_id) != g ||
                rsp_sum !== m_sum || rsp_cout !== m_cout) begin
                errors++;
                $display("FAIL rr_rsp_%0d: got id=%0d sum=%h cout=%b want %0d/%h/%b",
                         cyc, rsp_id, rsp_sum, rsp_cout, g, m_sum, m_cout);
            end
            if (g >= 0)
                set_req(g, 16'($urandom), 16'($urandom), 1'($urandom), 1'b0);
        end
        clear_reqs();
        tick(g);
    endtask

    task automatic test_backpressure();
        int g;
        logic [1:0] hid;
        logic [15:0] hsum;
        logic hc;
        clear_reqs();
        rsp_ready = 1;
        set_req(3, 16'h7000, 16'h9001, 1'b0, 1'b0);
        tick(g);
        rsp_ready = 0;
        hid = rsp_id; hsum = rsp_sum; hc = rsp_cout;
        for (int i = 0; i < N; i++)
            set_req(i, 16'($urandom), 16'($urandom), 1'b0, 1'b0);
        for (int cyc = 0; cyc < 5; cyc++) begin
            #1;
            checks++;
            if (req_ready !== 4'b0000 || rsp_valid !== 1'b1 || rsp_id !== hid ||
                rsp_sum !== hsum || rsp_cout !== hc) begin
                errors++;
                $display("FAIL bp_hold_%0d: got rdy=%b v=%b id=%0d sum=%h want 0000/1/%0d/%h",
                         cyc, req_ready, rsp_valid, rsp_id, rsp_sum, hid, hsum);
            end
            tick(g);
        end
        rsp_ready = 1;
        #1;
        checks++;
        if (req_ready !== 4'b0001 || req_ready !== m_ready()) begin errors++;
            $display("FAIL bp_release: got %b want 0001", req_ready); end
        tick(g);
        clear_reqs();
        #1;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_sum !== m_sum) begin errors++;
            $display("FAIL bp_new: got v=%b id=%0d sum=%h want 1/0/%h",
                     rsp_valid, rsp_id, rsp_sum, m_sum); end
        tick(g);
    endtask

    task automatic test_carry_isolation();
        int g;
        rsp_ready = 1;
        clear_reqs();
        set_req(2, 16'h8000, 16'h8000, 1'b0, 1'b0);
        tick(g);
        for (int k = 0; k < 3; k++) begin
            clear_reqs();
            set_req(3, 16'($urandom_range(0, 16'h7FFF)), 16'($urandom_range(0, 16'h7FFF)),
                    1'b0, 1'b0);
            tick(g);
            checks++;
            if (rsp_cout !== 1'b0 || rsp_id !== 2'd3 || rsp_sum !== m_sum) begin errors++;
                $display("FAIL iso_req3_%0d: got id=%0d sum=%h cout=%b want 3/%h/0",
                         k, rsp_id, rsp_sum, rsp_cout, m_sum); end
        end
        clear_reqs();
        set_req(2, 16'h0001, 16'h0001, 1'b0, 1'b1);
        tick(g);
        clear_reqs();
        checks++;
        if (rsp_sum !== 16'h0003 || rsp_id !== 2'd2 || rsp_cout !== 1'b0) begin errors++;
            $display("FAIL iso_chain: got id=%0d sum=%h cout=%b want 2/0003/0",
                     rsp_id, rsp_sum, rsp_cout); end
        tick(g);
    endtask

    task automatic test_reset_mid();
        int g;
        rsp_ready = 1;
        clear_reqs();
        set_req(2, 16'h8000, 16'h8000, 1'b0, 1'b0);
        tick(g);
        rsp_ready = 0;
        for (int i = 0; i < N; i++) set_req(i, 16'h0000, 16'h0000, 1'b0, 1'b1);
        rst = 1;
        tick(g);
        rst = 0;
        rsp_ready = 1;
        #1;
        checks++;
        if (rsp_valid !== 1'b0) begin errors++;
            $display("FAIL rst_mid_valid: got %b want 0", rsp_valid); end
        checks++;
        if (req_ready !== 4'b0001) begin errors++;
            $display("FAIL rst_mid_first: got %b want 0001", req_ready); end
        for (int i = 0; i < N; i++) begin
            tick(g);
            checks++;
            if (int'(rsp_id) != i || rsp_sum !== 16'h0000 || rsp_cout !== 1'b0) begin
                errors++;
                $display("FAIL rst_mid_carry_%0d: got id=%0d sum=%h want %0d/0000",
                         i, rsp_id, rsp_sum, i);
            end
        end
        clear_reqs();
        tick(g);
    endtask

    task automatic test_random();
        int g;
        clear_reqs();
        for (int cyc = 0; cyc < 300; cyc++) begin
            for (int i = 0; i < N; i++)
                if (!req_valid[i] && $urandom_range(0, 2) != 0)
                    set_req(i, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
            rsp_ready = ($urandom_range(0, 3) != 0);
            #1;
            checks++;
            if (req_ready !== m_ready()) begin errors++;
                $display("FAIL rand_ready_%0d: got %b want %b", cyc, req_ready, m_ready()); end
            tick(g);
            if (g >= 0) req_valid[g] = 1'b0;
            checks++;
            if (rsp_valid !== m_rv || int'(rsp_id) != m_id ||
                rsp_sum !== m_sum || rsp_cout !== m_cout) begin
                errors++;
                $display("FAIL rand_rsp_%0d: got %b/%0d/%h/%b want %b/%0d/%h/%b", cyc,
                         rsp_valid, rsp_id, rsp_sum, rsp_cout, m_rv, m_id, m_sum, m_cout);
            end
        end
        clear_reqs();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_chain();
        test_round_robin();
        test_backpressure();
        test_carry_isolation();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ks_add_arbiter.md
Name: ks_add_arbiter

Overview:
- Shares one 16-bit KoggeStone adder instance among N_REQ requesters.
- Round-robin arbitration, valid/ready handshakes on every requester port and on a single response port.
- Per-requester carry flags allow multi-word (chained) additions to be interleaved across requesters without corrupting each other.
- Sits between the datapath issue logic and the shared adder; one registered result per cycle.

Parameters:
- N_REQ, 4, number of requesters (2..8); ID width = clog2(N_REQ).
- W, 16, operand width; fixed at 16 to match KoggeStone, any other value is an elaboration error.

Ports:
- clk  input  1  clock, all logic rising-edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  N_REQ  request i valid.
- req_ready  output  N_REQ  request i accepted this cycle (one-hot or zero).
- req_a  input  N_REQ*16  operand A, requester i at bits [16i+15:16i].
- req_b  input  N_REQ*16  operand B, same packing.
- req_cin  input  N_REQ  carry-in, used when req_chain[i]=0.
- req_chain  input  N_REQ  1: use requester i's stored carry flag as Cin.
- rsp_valid  output  1  response register holds a result.
- rsp_ready  input  1  consumer accepts response.
- rsp_id  output  clog2(N_REQ)  requester index of the result.
- rsp_sum  output  16  sum.
- rsp_cout  output  1  carry-out.

Behaviour:
- Reset values: rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_cout=0, all carry_q=0, rr_ptr=0. Reset in any cycle discards the held response and any same-cycle acceptance.
- Slot free: slot_free = !rsp_valid | rsp_ready.
- Grant:
  - When slot_free, grant the first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ... mod N_REQ.
  - req_ready = one-hot grant, combinational from req_valid, rsp_valid, rsp_ready and rr_ptr.
  - No grant when !slot_free: req_ready all 0.
  - Requesters must hold valid and operands stable until ready. The arbiter never requires ready before valid.
- Pointer: on a grant to i, rr_ptr <= (i+1) mod N_REQ. Otherwise rr_ptr is unchanged.
- Datapath:
  - The adder input mux selects the granted requester's A and B.
  - Cin = req_chain[g] ? carry_q[g] : req_cin[g].
  - The adder is purely combinational, and its outputs are registered.
- Latency: accept in cycle t, so rsp_valid=1 with the result in cycle t+1. Throughput is one op per cycle with rsp_ready held high.
- Response register:
  - On a grant, load rsp_sum, rsp_cout and rsp_id=g, and set rsp_valid=1.
  - Else if rsp_ready, clear rsp_valid and keep the data fields unchanged.
  - While rsp_valid & !rsp_ready, all response fields are stable.
- Carry flags:
  - On a grant to g, carry_q[g] <= adder Cout.
  - Other requesters' flags are untouched.
  - The flag updates at acceptance, independent of when the response drains.
- Simultaneous drain and accept: the new result replaces the drained one in the same edge, with no bubble.
- No requests: the pointer holds and the response drains normally.

Test Plan:
- Basic add: req0 A=0x1234, B=0x4321, cin=0, chain=0, rsp_ready=1 → next cycle rsp_valid=1, id=0, sum=0x5555, cout=0. With cin=1 the sum is 0x5556.
- Chained add on req1:
  - First op 0xFFFF+0x0001, chain=0, cin=0 → sum=0x0000, cout=1.
  - Then 0x0000+0x0000 with chain=1 → sum=0x0001, cout=0, and carry_q[1] returns to 0.
- Round-robin: all four requesters valid continuously, rsp_ready=1 → grant order 0,1,2,3,0,1,... one per cycle, and rsp_id follows one cycle later.
- Backpressure:
  - Hold rsp_ready=0 after one result → req_ready=0 for every requester and response fields stable for 5 cycles.
  - Raise rsp_ready → that cycle drains and accepts the next request, with a new result the following cycle.
- Carry isolation: req2 computes 0x8000+0x8000 (carry_q[2]=1). Interleave req3 ops with cout=0, then req2 0x0001+0x0001 with chain=1 → sum=0x0003.
- Reset mid-operation: assert rst with rsp_valid=1 and carry_q[2]=1 → next cycle rsp_valid=0, carries 0, rr_ptr=0. With all requesters valid after release, req0 is granted first.
